// File: rtl/pll_lock_monitor.sv
// PLL supervisor on the reference clock domain: cycles the PLL reset, qualifies lock with a
// stability timer, measures the PLL output frequency per window and gates the system reset.
module pll_lock_monitor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned WINDOW_CYCLES  = 5000,
  parameter int unsigned EXPECTED_EDGES = 120,
  parameter int unsigned TOLERANCE      = 2,
  parameter int unsigned FAULT_HOLD     = 256
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       pll_clk,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       freq_ok,
  output logic       fault,
  output logic [7:0] edge_count
);

  localparam int unsigned CntW = 16;
  localparam int unsigned WinW = $clog2(WINDOW_CYCLES);

  typedef enum logic [2:0] {StResetPll, StWaitLock, StMeasure, StRun, StFault} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [7:0]        edge_cnt_q, edge_cnt_d;
  logic [7:0]        edge_count_q, edge_count_d;
  logic              freq_ok_q, freq_ok_d;
  logic              pll_rst_q, pll_rst_d;
  logic              sys_rst_n_q, sys_rst_n_d;
  logic              fault_q, fault_d;
  logic              lock_s1_q, lock_s2_q;
  logic              clk_s1_q, clk_s2_q, clk_s3_q;

  logic              edge_pulse;
  logic              win_end;
  logic [7:0]        edge_sum;
  logic [8:0]        sum9;
  logic              pass;

  // Synchronizers for the asynchronous lock flag and the PLL clock sampled as data.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      clk_s1_q  <= 1'b0;
      clk_s2_q  <= 1'b0;
      clk_s3_q  <= 1'b0;
    end else begin
      lock_s1_q <= pll_locked;
      lock_s2_q <= lock_s1_q;
      clk_s1_q  <= pll_clk;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
    end
  end

  assign edge_pulse = clk_s2_q & ~clk_s3_q;
  assign win_end    = (win_q == WinW'(WINDOW_CYCLES - 1));
  // Saturating count including this cycle's edge, so a terminal-cycle edge lands in the window.
  assign edge_sum   = (edge_cnt_q == 8'hff) ? 8'hff : edge_cnt_q + {7'd0, edge_pulse};
  // 9-bit so the lower bound cannot underflow and the upper add cannot overflow.
  assign sum9       = {1'b0, edge_sum};
  assign pass       = ((sum9 + 9'(TOLERANCE)) >= 9'(EXPECTED_EDGES)) &&
                      (sum9 <= 9'(EXPECTED_EDGES + TOLERANCE));

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    edge_cnt_d   = edge_cnt_q;
    edge_count_d = edge_count_q;
    freq_ok_d    = freq_ok_q;

    unique case (state_q)
      StResetPll: begin
        if (cnt_q == CntW'(PLL_RST_CYCLES - 1)) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        if (!lock_s2_q) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(LOCK_STABLE - 1)) begin
          state_d    = StMeasure;
          cnt_d      = '0;
          win_d      = '0;
          edge_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StMeasure: begin
        if (!lock_s2_q) begin
          // Lock loss while qualifying is not a fault; results are discarded.
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (win_end) begin
          win_d        = '0;
          edge_cnt_d   = '0;
          edge_count_d = edge_sum;
          freq_ok_d    = pass;
          state_d      = pass ? StRun : StFault;
          cnt_d        = '0;
        end else begin
          win_d      = win_q + WinW'(1);
          edge_cnt_d = edge_sum;
        end
      end
      StRun: begin
        if (win_end) begin
          win_d        = '0;
          edge_cnt_d   = '0;
          edge_count_d = edge_sum;
          freq_ok_d    = pass;
        end else begin
          win_d      = win_q + WinW'(1);
          edge_cnt_d = edge_sum;
        end
        if (!lock_s2_q || (win_end && !pass)) begin
          state_d = StFault;
          cnt_d   = '0;
        end
      end
      StFault: begin
        if (cnt_q == CntW'(FAULT_HOLD - 1)) begin
          state_d   = StResetPll;
          cnt_d     = '0;
          freq_ok_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StResetPll;
        cnt_d   = '0;
      end
    endcase

    pll_rst_d   = (state_d == StResetPll);
    sys_rst_n_d = (state_d == StRun);
    fault_d     = (state_d == StFault);
  end

  // State, counters and output registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StResetPll;
      cnt_q        <= '0;
      win_q        <= '0;
      edge_cnt_q   <= '0;
      edge_count_q <= '0;
      freq_ok_q    <= 1'b0;
      pll_rst_q    <= 1'b1;
      sys_rst_n_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      edge_cnt_q   <= edge_cnt_d;
      edge_count_q <= edge_count_d;
      freq_ok_q    <= freq_ok_d;
      pll_rst_q    <= pll_rst_d;
      sys_rst_n_q  <= sys_rst_n_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign freq_ok    = freq_ok_q;
  assign fault      = fault_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: frequency table plus bring-up, glitch, lock-loss and
// reset corner sequences.
module tb_pll_lock_monitor;

  localparam int LockStable = 1024;
  localparam int WinCycles  = 5000;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_clk = 1'b0;
  logic       pll_rst, sys_rst_n, freq_ok, fault;
  logic [7:0] edge_count;

  int n_vec = 0;
  int n_err = 0;

  pll_lock_monitor dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_clk    (pll_clk),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .freq_ok    (freq_ok),
    .fault      (fault),
    .edge_count (edge_count)
  );

  always #10 refclk = ~refclk;

  // pll_clk pattern repeating every 5000 refclk cycles with exactly k_edges rising edges, so
  // any 5000-cycle window sees exactly k_edges regardless of its alignment.
  int k_edges = 0;
  int frame = 0;
  always @(negedge refclk) begin
    int step;
    step = (k_edges == 0) ? 1 : WinCycles / k_edges;
    pll_clk <= (k_edges != 0) && (frame / step < k_edges) && (frame % step < step / 2);
    frame <= (frame == WinCycles - 1) ? 0 : frame + 1;
  end

  typedef struct {
    int k;
    int exp_count;
    bit exp_ok;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return sys_rst_n;
      1:       return fault;
      2:       return sys_rst_n | fault;
      default: return pll_rst;
    endcase
  endfunction

  // Count posedges until the selected signal reads val (#1 after the edge); -1 on timeout.
  task automatic wait_val(input int sel, input logic val, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge refclk);
      #1;
      if (get_sig(sel) == val) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout sel=%0d: got no %0b within %0d cycles", sel, val, budget);
    end
  endtask

  // Reset pulse with lock low; returns at the negedge where rst_n is released.
  task automatic do_reset();
    @(negedge refclk);
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    rst_n = 1'b1;
  endtask

  // Number of negedge samples, starting at the current one, with pll_rst high.
  task automatic measure_pll_rst(output int n);
    n = 0;
    while (pll_rst && n < 100) begin
      n++;
      @(negedge refclk);
    end
  endtask

  initial begin
    int n;
    int clean_n;
    clean_n = 0;
    vecs[0] = '{k: 120, exp_count: 120, exp_ok: 1'b1};
    vecs[1] = '{k: 118, exp_count: 118, exp_ok: 1'b1};
    vecs[2] = '{k: 117, exp_count: 117, exp_ok: 1'b0};
    vecs[3] = '{k: 122, exp_count: 122, exp_ok: 1'b1};
    vecs[4] = '{k: 123, exp_count: 123, exp_ok: 1'b0};
    vecs[5] = '{k: 125, exp_count: 125, exp_ok: 1'b0};
    vecs[6] = '{k: 600, exp_count: 255, exp_ok: 1'b0};

    // Reset values.
    repeat (3) @(negedge refclk);
    check("rst_pll_rst", int'(pll_rst), 1);
    check("rst_sys_rst_n", int'(sys_rst_n), 0);
    check("rst_freq_ok", int'(freq_ok), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_edge_count", int'(edge_count), 0);

    // Bring-up for each frequency in the table.
    for (int v = 0; v < 7; v++) begin
      k_edges = vecs[v].k;
      do_reset();
      measure_pll_rst(n);
      check($sformatf("v%0d_pll_rst_len", v), n, 16);
      repeat (34) @(negedge refclk);
      pll_locked = 1'b1;
      wait_val(2, 1'b1, 8000, n);
      if (v == 0) begin
        clean_n = n;
        check_range("bringup_delay", n, LockStable + WinCycles, LockStable + WinCycles + 6);
      end
      check($sformatf("v%0d_edge_count", v), int'(edge_count), vecs[v].exp_count);
      check($sformatf("v%0d_freq_ok", v), int'(freq_ok), int'(vecs[v].exp_ok));
      check($sformatf("v%0d_sys_rst_n", v), int'(sys_rst_n), int'(vecs[v].exp_ok));
      check($sformatf("v%0d_fault", v), int'(fault), int'(!vecs[v].exp_ok));
    end

    // Saturated case is now in FAULT: hold length, then a fresh PLL reset.
    n = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge refclk);
      #1;
      if (!fault) break;
      n++;
    end
    check("fault_hold_len", n, 256);
    check("retry_pll_rst", int'(pll_rst), 1);
    check("retry_freq_ok", int'(freq_ok), 0);
    check("retry_sys_rst_n", int'(sys_rst_n), 0);

    // One-cycle lock glitch late in the stability count restarts qualification.
    k_edges = 120;
    do_reset();
    measure_pll_rst(n);
    pll_locked = 1'b1;
    repeat (1000) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    wait_val(0, 1'b1, 8000, n);
    check("glitch_restart_delay", n, clean_n);

    // Lock loss in RUN: system reset within 4 cycles, fault, then retry.
    @(negedge refclk);
    pll_locked = 1'b0;
    wait_val(0, 1'b0, 10, n);
    check_range("lockloss_latency", n, 1, 4);
    check("lockloss_fault", int'(fault), 1);
    wait_val(1, 1'b0, 300, n);
    check("lockloss_retry_pll_rst", int'(pll_rst), 1);

    // Asynchronous reset mid-window in RUN, then a full bring-up again.
    @(negedge refclk);
    pll_locked = 1'b1;
    wait_val(0, 1'b1, 8000, n);
    repeat (100) @(negedge refclk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_pll_rst", int'(pll_rst), 1);
    check("async_sys_rst_n", int'(sys_rst_n), 0);
    check("async_freq_ok", int'(freq_ok), 0);
    check("async_fault", int'(fault), 0);
    check("async_edge_count", int'(edge_count), 0);
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
    wait_val(0, 1'b1, 8000, n);
    check("rebringup_freq_ok", int'(freq_ok), 1);
    check("rebringup_edge_count", int'(edge_count), 120);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Supervises the 1.2 MHz system PLL from the 50 MHz reference side. Drives the PLL reset, qualifies `locked` with a stability timer, measures the PLL output frequency against the reference, and releases the downstream active-low system reset only when lock and frequency are both good. On loss of lock or a frequency fault it re-asserts system reset and re-cycles the PLL.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: refclk cycles `pll_rst` is held high per reset attempt.
- `LOCK_STABLE`, 1024: consecutive synchronized-locked cycles required before measuring.
- `WINDOW_CYCLES`, 5000: measurement window in refclk cycles (100 µs).
- `EXPECTED_EDGES`, 120: nominal pll_clk rising edges per window.
- `TOLERANCE`, 2: allowed |count − EXPECTED_EDGES|, inclusive.
- `FAULT_HOLD`, 256: refclk cycles spent in FAULT before retry.

Ports:
- `refclk` in 1: 50 MHz reference clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock indicator, asynchronous to refclk.
- `pll_clk` in 1: PLL output, sampled as data.
- `pll_rst` out 1: active-high PLL reset request.
- `sys_rst_n` out 1: active-low downstream reset; high only in RUN.
- `freq_ok` out 1: last completed window was in tolerance.
- `fault` out 1: high in FAULT state.
- `edge_count` out 8: edge count of the last completed window, saturating at 255.

## Operation
- `pll_locked` and `pll_clk` each pass through a 2-flop synchronizer. A third flop on `pll_clk` gives the rising-edge pulse `edge = s & ~s_d`.
- States:
  - RESET_PLL: `pll_rst`=1 for PLL_RST_CYCLES cycles, then WAIT_LOCK.
  - WAIT_LOCK: stability counter increments while synced locked is 1 and clears to 0 on any 0. At LOCK_STABLE go to MEASURE.
  - MEASURE: one window. If synced locked drops, go to WAIT_LOCK with no fault. At window end: pass goes to RUN, fail goes to FAULT.
  - RUN: `sys_rst_n`=1. Windows repeat back to back. A lock drop goes to FAULT immediately. A failed window goes to FAULT at window end.
  - FAULT: `fault`=1, `sys_rst_n`=0. After FAULT_HOLD cycles go to RESET_PLL. `fault` clears on leaving FAULT.
- Window counter runs 0..WINDOW_CYCLES−1 and restarts at 0 the next cycle.
  - An edge pulse on the terminal cycle counts in the ending window.
  - The edge counter clears at window start.
  - The edge counter saturates at 255 and does not wrap.
- Pass test: EXPECTED_EDGES−TOLERANCE ≤ count ≤ EXPECTED_EDGES+TOLERANCE. Compute it in 9-bit unsigned so there is no underflow.
- `edge_count` and `freq_ok` update only at window end, in MEASURE and RUN. `freq_ok` is forced to 0 on entry to RESET_PLL.
- Simultaneous events:
  - Lock drop on the window-end cycle in RUN gives FAULT, with `freq_ok`/`edge_count` still updated.
  - In MEASURE, lock drop takes priority: go to WAIT_LOCK with no update.

## Timing
- All outputs are registered.
- Reset values: `pll_rst`=1, `sys_rst_n`=0, `freq_ok`=0, `fault`=0, `edge_count`=0, state RESET_PLL, all counters 0.
- Async reset mid-operation returns immediately to the reset values.
- Lock-drop detection: `sys_rst_n` falls ≤4 refclk cycles after `pll_locked` falls (2 sync + state + output register).
- Minimum time from `rst_n` release to `sys_rst_n`=1 ≈ PLL_RST_CYCLES + 2 + LOCK_STABLE + WINDOW_CYCLES + 2 cycles.
- `pll_rst` is high exactly PLL_RST_CYCLES cycles per attempt.

## Test plan
- Clean bring-up: 1.2 MHz `pll_clk`, `pll_locked` rises 50 cycles after `rst_n` release -> `pll_rst` high 16 cycles; `sys_rst_n` rises once after 1024 + 5000 cycles; `freq_ok`=1; `edge_count` ∈ {119, 120, 121}.
- Wrong frequency: 1.25 MHz `pll_clk` -> `edge_count`=125 at window end; `fault`=1 for 256 cycles; then `pll_rst` pulses again; `sys_rst_n` stays 0.
- Lock glitch in WAIT_LOCK: `pll_locked` low 1 cycle at stability count 1000 -> counter restarts; MEASURE entered 1024 cycles after the glitch.
- Lock loss in RUN: drop `pll_locked` -> `sys_rst_n`=0 within 4 cycles; `fault`=1; retry sequence follows.
- Saturation: 6 MHz `pll_clk` (600 edges) -> `edge_count`=255, `freq_ok`=0, FAULT.
- Mid-window `rst_n` assertion in RUN -> all outputs at reset values in the same cycle; full bring-up repeats after release.
